// File: rtl/key_pkg.sv
// Shared types and width helpers for the key debouncer array.
package key_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        UP,
        FILT_DN,
        DOWN,
        FILT_UP
    } key_fsm_t;

    // Ceiling log2 used to size counters from their maximum value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 32'd1;
        end
        return result;
    endfunction

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = clog2(max_val + 32'd1);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/key_tick_gen.sv
// Free-running tick divider shared by all debounce channels.
// tick is high for one clk out of every TICK_DIV clk; rst restarts the phase.
module key_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    import key_pkg::*;

    localparam int unsigned    DIV_W    = cnt_width(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Tick on the last count of the period, then wrap to zero.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Divider register, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so all flops update together at the edge.
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/key_debounce_array.sv
// N-channel push-button debouncer.
// Each pin is polarity-normalised, synchronised (2 FF), edge-detected (1 FF) and
// qualified by a per-channel FSM counting shared debounce ticks.
// Optional long-press detection is built when macro KEY_LONGPRESS_EN is defined;
// otherwise key_long is tied low and no hold counters exist.
module key_debounce_array #(
    parameter int unsigned N_KEYS     = 4,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned DEB_TICKS  = 20,
    parameter int unsigned LONG_TICKS = 1000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_long
);
    import key_pkg::*;

    localparam int unsigned      CNT_W   = cnt_width(DEB_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_TICKS);

    // Reject configurations the filter cannot support.
    if (N_KEYS < 1 || N_KEYS > 16 || TICK_DIV < 1 || DEB_TICKS < 2 || LONG_TICKS < 1) begin : g_bad_params
        $error("key_debounce_array: parameter out of range");
    end

    logic tick;

    key_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Internal level convention: 1 = pressed, 0 = released.
    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [N_KEYS-1:0] edge_q,  edge_d;

    // Input path: normalise polarity, shift through synchroniser and edge register.
    always_comb begin
        sync1_d = ACTIVE_LOW ? ~key_in : key_in;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
    end

    // Sync and edge registers load the released level so reset creates no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            edge_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_fsm_t         state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_o;
        logic             release_o;
        logic             press_edge;
        logic             release_edge;

        assign press_edge   =  sync2_q[i] & ~edge_q[i];
        assign release_edge = ~sync2_q[i] &  edge_q[i];

        // Debounce FSM: an opposing edge always wins over a tick or acceptance.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_o   = 1'b0;
            release_o = 1'b0;
            unique case (state_q)
                UP: begin
                    if (press_edge) begin
                        state_d = FILT_DN;
                        cnt_d   = '0;
                    end
                end
                FILT_DN: begin
                    if (release_edge) begin
                        state_d = UP;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = DOWN;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        press_o = 1'b1;
                    end else if (tick) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DOWN: begin
                    if (release_edge) begin
                        state_d = FILT_UP;
                        cnt_d   = '0;
                    end
                end
                FILT_UP: begin
                    if (press_edge) begin
                        state_d = DOWN;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = UP;
                        cnt_d     = '0;
                        level_d   = 1'b1;
                        release_o = 1'b1;
                    end else if (tick) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = UP;
                    cnt_d   = '0;
                end
            endcase
        end

        // Per-channel state, filter counter and debounced level.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= UP;
                cnt_q   <= '0;
                level_q <= 1'b1;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
            end
        end

        // Strobes are dropped while reset is asserted.
        assign key_press[i]   = press_o   & ~rst;
        assign key_release[i] = release_o & ~rst;
        assign key_state[i]   = level_q;

`ifdef KEY_LONGPRESS_EN
        localparam int unsigned      HOLD_W   = cnt_width(LONG_TICKS);
        localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              long_o;

        // Hold counter: cleared by a new accepted press or a completed release,
        // frozen during release filtering so a bounce back keeps the count.
        always_comb begin
            hold_d = hold_q;
            long_o = 1'b0;
            if ((state_q == FILT_DN && state_d == DOWN) || (state_q == FILT_UP && state_d == UP)) begin
                hold_d = '0;
            end else if (state_q == DOWN && state_d == DOWN && tick && hold_q != HOLD_MAX) begin
                hold_d = hold_q + HOLD_W'(1);
                long_o = (hold_q == HOLD_MAX - HOLD_W'(1));
            end
        end

        // Hold counter register.
        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_d;
            end
        end

        assign key_long[i] = long_o & ~rst;
`else
        assign key_long[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Self-checking bench for key_debounce_array (N_KEYS=2, TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=8).
// A reference model predicts strobes and debounced-level changes into queues; a monitor
// pops and compares whenever the DUT shows a strobe or a key_state change.
module tb_key_debounce_array;

    localparam int N    = 2;
    localparam int TD   = 4;
    localparam int DEB  = 3;
    localparam int LONG = 8;
    localparam bit AL   = 1'b1;
`ifdef KEY_LONGPRESS_EN
    localparam int EXP_LONG = 1;
`else
    localparam int EXP_LONG = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key_in = '1;
    logic [N-1:0] key_press, key_release, key_state, key_long;

    key_debounce_array #(
        .N_KEYS     (N),
        .TICK_DIV   (TD),
        .DEB_TICKS  (DEB),
        .LONG_TICKS (LONG),
        .ACTIVE_LOW (AL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_press   (key_press),
        .key_release (key_release),
        .key_state   (key_state),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input bit ok, input string what, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", what, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int cyc; logic [N-1:0] p; logic [N-1:0] r; logic [N-1:0] l; } strobe_t;
    typedef struct { int cyc; logic [N-1:0] s; } level_t;
    strobe_t sb_q[$];
    level_t  lvl_q[$];

    logic [N-1:0] r_hist[$];   // pressed level driven during the cycle after edge k
    int           gcyc = 0;
    int           e = 0;       // edges since last reset edge
    bit           rst_prev = 1'b1;
    logic [N-1:0] m_acc, m_filt, m_pend;
    int           m_cnt[N];
    int           m_hold[N];

    function automatic logic r_at(input int k, input int ch);
        if (k < 0) return 1'b0;
        return r_hist[k][ch];
    endfunction

    always @(negedge clk) begin : model
        logic [N-1:0] p_n, r_n, l_n;
        bit tk, tk1, nxt_chg, changed;
        gcyc++;
        if (rst_prev) begin
            if (m_acc != '0) lvl_q.push_back('{gcyc, {N{1'b1}}});
            e = 0;
            r_hist.delete();
            m_acc = '0; m_filt = '0; m_pend = '0;
            for (int ch = 0; ch < N; ch++) begin m_cnt[ch] = 0; m_hold[ch] = 0; end
        end else begin
            e++;
            tk = (e % TD) == 0;
            changed = 1'b0;
            for (int ch = 0; ch < N; ch++) begin
                if (m_pend[ch]) begin
                    m_acc[ch]  = ~m_acc[ch];
                    m_filt[ch] = 1'b0;
                    m_pend[ch] = 1'b0;
                    m_hold[ch] = 0;
                    changed    = 1'b1;
                end else if (r_at(e-3, ch) != r_at(e-4, ch)) begin
                    if (r_at(e-3, ch) != m_acc[ch]) begin
                        m_filt[ch] = 1'b1;
                        m_cnt[ch]  = 0;
                    end else begin
                        m_filt[ch] = 1'b0;
                    end
                end else begin
                    if (m_filt[ch] && tk && m_cnt[ch] < DEB) m_cnt[ch]++;
                    if (m_acc[ch] && !m_filt[ch] && tk && m_hold[ch] < LONG) m_hold[ch]++;
                end
            end
            if (changed) lvl_q.push_back('{gcyc, ~m_acc});
        end
        r_hist.push_back(AL ? ~key_in : key_in);
        p_n = '0; r_n = '0; l_n = '0;
        if (!rst) begin
            tk1 = ((e + 1) % TD) == 0;
            for (int ch = 0; ch < N; ch++) begin
                nxt_chg = r_at(e-2, ch) != r_at(e-3, ch);
                if (m_filt[ch] && m_cnt[ch] == DEB && !nxt_chg) begin
                    if (m_acc[ch]) r_n[ch] = 1'b1; else p_n[ch] = 1'b1;
                    m_pend[ch] = 1'b1;
                end
                if (EXP_LONG == 1 && m_acc[ch] && !m_filt[ch] && m_hold[ch] == LONG - 1 && tk1 && !nxt_chg)
                    l_n[ch] = 1'b1;
            end
            if ((p_n | r_n | l_n) != '0) sb_q.push_back('{gcyc, p_n, r_n, l_n});
        end
        rst_prev = rst;
    end

    // ---------------- monitor ----------------
    bit           mon_en = 1'b0;
    logic [N-1:0] prev_state;
    int           n_press0 = 0, n_press_any = 0, n_long0 = 0;

    initial begin : monitor
        strobe_t s;
        level_t  l;
        wait (mon_en);
        prev_state = {N{1'b1}};
        forever begin
            @(negedge clk);
            #1;
            while (sb_q.size() > 0 && sb_q[0].cyc < gcyc) begin
                s = sb_q.pop_front();
                check(1'b0, "missed_strobe_cycle", gcyc, s.cyc);
            end
            while (lvl_q.size() > 0 && lvl_q[0].cyc < gcyc) begin
                l = lvl_q.pop_front();
                check(1'b0, "missed_state_change", gcyc, l.cyc);
            end
            if ((key_press | key_release | key_long) != '0) begin
                if (key_press[0]) n_press0++;
                if (key_press != '0) n_press_any++;
                if (key_long[0]) n_long0++;
                check((key_press & key_release) == '0, "press_and_release", int'(key_press & key_release), 0);
                if (sb_q.size() == 0 || sb_q[0].cyc != gcyc) begin
                    check(1'b0, "unexpected_strobe", int'({key_press, key_release, key_long}), 0);
                end else begin
                    s = sb_q.pop_front();
                    check({key_press, key_release, key_long} == {s.p, s.r, s.l}, "strobe_value",
                          int'({key_press, key_release, key_long}), int'({s.p, s.r, s.l}));
                end
            end
            if (key_state != prev_state) begin
                if (lvl_q.size() == 0 || lvl_q[0].cyc != gcyc) begin
                    check(1'b0, "unexpected_state_change", int'(key_state), int'(prev_state));
                end else begin
                    l = lvl_q.pop_front();
                    check(key_state == l.s, "state_value", int'(key_state), int'(l.s));
                end
            end
            prev_state = key_state;
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [N-1:0] k, input int n);
        @(posedge clk); #1;
        key_in = k;
        repeat (n - 1) @(posedge clk);
    endtask

    // Count posedges from the drive until the selected strobe shows on a masked bit.
    task automatic wait_strobe(input logic [N-1:0] mask, input bit rel, output int n);
        n = 0;
        forever begin
            @(negedge clk); #2;
            if (((rel ? key_release : key_press) & mask) != '0) break;
            n++;
            if (n > 40) break;
        end
    endtask

    initial begin : stim
        int n, p0, l0, dur[N];
        logic [N-1:0] k;
        rst = 1'b1; key_in = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk); #2;
        check(key_state == 2'b11, "reset_key_state", int'(key_state), 3);
        check(key_press == '0 && key_release == '0 && key_long == '0, "reset_strobes",
              int'({key_press, key_release, key_long}), 0);
        repeat (50) @(posedge clk);
        check(n_press_any == 0, "idle_after_reset_press", n_press_any, 0);

        // Clean press of key 0.
        @(posedge clk); #1 key_in = 2'b10;
        wait_strobe(2'b01, 1'b0, n);
        check(n >= 12 && n <= 15, "press_latency_12_to_15", n, 12);
        repeat (3) @(negedge clk);
        check(key_state == 2'b10, "state_after_press", int'(key_state), 2);

        // Clean release of key 0.
        @(posedge clk); #1 key_in = 2'b11;
        wait_strobe(2'b01, 1'b1, n);
        check(n >= 12 && n <= 15, "release_latency_12_to_15", n, 12);
        repeat (3) @(negedge clk);
        check(key_state == 2'b11, "state_after_release", int'(key_state), 3);

        // Bouncing key 0 never qualifies.
        p0 = n_press0;
        for (int b = 0; b < 4; b++) begin
            hold(2'b10, 5);
            hold(2'b11, 3);
        end
        repeat (40) @(posedge clk);
        check(n_press0 == p0, "bounce_no_press", n_press0 - p0, 0);
        @(negedge clk); #2;
        check(key_state == 2'b11, "bounce_state", int'(key_state), 3);

        // Both keys in the same cycle.
        @(posedge clk); #1 key_in = 2'b00;
        wait_strobe(2'b11, 1'b0, n);
        check(key_press == 2'b11, "both_press_same_cycle", int'(key_press), 3);
        hold(2'b11, 30);

        // Long hold on key 0.
        l0 = n_long0;
        @(posedge clk); #1 key_in = 2'b10;
        wait_strobe(2'b01, 1'b0, n);
        repeat (40) @(posedge clk);
        check(n_long0 - l0 == EXP_LONG, "long_press_count", n_long0 - l0, EXP_LONG);
        hold(2'b11, 30);

        // Reset in the middle of a press filter on key 1.
        p0 = n_press_any;
        @(posedge clk); #1 key_in = 2'b01;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1; key_in = 2'b11;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        check(n_press_any == p0, "rst_mid_filter_no_press", n_press_any - p0, 0);
        @(negedge clk); #2;
        check(key_state == 2'b11, "rst_mid_filter_state", int'(key_state), 3);

        // Randomised bouncing and holding on both channels, occasional reset.
        for (int ch = 0; ch < N; ch++) dur[ch] = 1;
        k = 2'b11;
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #1;
            for (int ch = 0; ch < N; ch++) begin
                dur[ch]--;
                if (dur[ch] <= 0) begin
                    k[ch]   = ~k[ch];
                    dur[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 60)) : int'($urandom_range(1, 8));
                end
            end
            key_in = k;
            rst = ($urandom_range(0, 699) == 0);
        end
        @(posedge clk); #1 rst = 1'b0; key_in = 2'b11;
        repeat (80) @(posedge clk);
        @(negedge clk); #2;
        check(sb_q.size() == 0, "strobe_queue_drained", sb_q.size(), 0);
        check(lvl_q.size() == 0, "state_queue_drained", lvl_q.size(), 0);
        check(key_state == 2'b11, "final_state", int'(key_state), 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
